// File: rtl/pc_pkg.sv
// Shared constants and types for the program counter.
//   PC_WIDTH        default width of the PC datapath
//   PC_RESET_VALUE  address forced by system reset and by clear
//   pc_sel_e        next-value select driven by the priority encoder
package pc_pkg;

    localparam int unsigned PC_WIDTH       = 16;
    localparam int unsigned PC_RESET_VALUE = 0;

    typedef enum logic [1:0] {
        SEL_CLEAR = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_INC   = 2'd2,
        SEL_HOLD  = 2'd3
    } pc_sel_e;

endpackage : pc_pkg

// File: rtl/program_counter_if.sv
// Control/address bundle between the CPU control logic and the program counter.
//   in    : address to load
//   load  : load in on the next edge
//   inc   : increment on the next edge
//   clear : synchronous clear to the reset address
//   out   : current PC value (registered)
interface program_counter_if
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             clear;
    logic [WIDTH-1:0] out;

    // CPU side: drives controls, observes the PC
    modport master (
        output in,
        output load,
        output inc,
        output clear,
        input  out
    );

    // PC side: samples controls, drives the PC
    modport slave (
        input  in,
        input  load,
        input  inc,
        input  clear,
        output out
    );

endinterface : program_counter_if

// File: rtl/pc_register.sv
// WIDTH-bit D register with asynchronous active-low reset to RESET_VALUE.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   d     : next value
//   q     : registered value
module pc_register
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule : pc_register

// File: rtl/program_counter.sv
// Hack-style program counter: each rising edge clears, loads, increments or holds.
//   clock : system clock
//   reset : asynchronous active-low system reset
//   bus   : slave side of program_counter_if (in/load/inc/clear in, out registered)
// Priority is clear > load > inc > hold; increment wraps modulo 2^WIDTH.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
    input  logic              clock,
    input  logic              reset,
    program_counter_if.slave  bus
);

    pc_sel_e          sel_c;
    logic [WIDTH-1:0] inc_c;
    logic [WIDTH-1:0] next_c;

    // Priority encoder over the control inputs
    always_comb begin
        sel_c = SEL_HOLD;
        if (bus.clear) begin
            sel_c = SEL_CLEAR;
        end else if (bus.load) begin
            sel_c = SEL_LOAD;
        end else if (bus.inc) begin
            sel_c = SEL_INC;
        end
    end

    // Incrementer; carry out is intentionally dropped so all-ones wraps to zero
    assign inc_c = bus.out + WIDTH'(1);

    // Next-value mux
    always_comb begin
        next_c = bus.out;
        case (sel_c)
            SEL_CLEAR: next_c = RESET_VALUE;
            SEL_LOAD:  next_c = bus.in;
            SEL_INC:   next_c = inc_c;
            SEL_HOLD:  next_c = bus.out;
            default:   next_c = bus.out;
        endcase
    end

    pc_register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_pc_register (
        .clock (clock),
        .reset (reset),
        .d     (next_c),
        .q     (bus.out)
    );

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Testbench for program_counter: directed scenarios plus randomized traffic
// checked against a reference model of the PC update rules.
module tb_program_counter;

    localparam int unsigned W   = 16;
    localparam int          MOD = 65536;
    localparam int          RV  = 0;

    logic clock;
    logic reset;

    program_counter_if #(.WIDTH(W)) pc ();

    program_counter #(
        .WIDTH       (W),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pc.slave)
    );

    int vectors;
    int miscompares;
    int exp_pc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive controls, take one rising edge, advance the model, then settle past the edge.
    task automatic apply(input logic c, input logic l, input logic i, input logic [W-1:0] d);
        pc.clear = c;
        pc.load  = l;
        pc.inc   = i;
        pc.in    = d;
        @(posedge clock);
        if (reset) begin
            if (c)      exp_pc = RV;
            else if (l) exp_pc = int'(d);
            else if (i) exp_pc = (exp_pc + 1) % MOD;
        end
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pc.in    = 16'd7;
        pc.load  = 1'b0;
        pc.inc   = 1'b0;
        pc.clear = 1'b0;
        #1 reset = 1'b0;
        #1;
        exp_pc = RV;
        vectors++;
        if (pc.out !== 16'(exp_pc)) begin
            miscompares++;
            $display("FAIL reset_async: out=%h expected=%h", pc.out, 16'(exp_pc));
        end
        // Edges with inc/load asserted are ignored while reset is held
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, k[0], 1'b1, 16'h00AA);
            vectors++;
            if (pc.out !== 16'(RV)) begin
                miscompares++;
                $display("FAIL reset_hold_edges: out=%h expected=%h", pc.out, 16'(RV));
            end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b0, 1'b0, 16'd7);
            vectors++;
            if (pc.out !== 16'(exp_pc)) begin
                miscompares++;
                $display("FAIL reset_idle: out=%h expected=%h", pc.out, 16'(exp_pc));
            end
        end
    endtask

    task automatic test_clear_count();
        apply(1'b0, 1'b1, 1'b0, 16'h0042);
        apply(1'b1, 1'b0, 1'b1, 16'h0000);
        vectors++;
        if (pc.out !== 16'h0000) begin
            miscompares++;
            $display("FAIL clear_over_inc: out=%h expected=0000", pc.out);
        end
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 1'b0, 1'b1, 16'h0000);
            vectors++;
            if (pc.out !== 16'(k)) begin
                miscompares++;
                $display("FAIL count_%0d: out=%h expected=%h", k, pc.out, 16'(k));
            end
        end
    endtask

    task automatic test_load_priority();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b1, 1'b1, 16'd7);
            vectors++;
            if (pc.out !== 16'd7) begin
                miscompares++;
                $display("FAIL load_over_inc: out=%h expected=0007", pc.out);
            end
        end
        for (int k = 8; k <= 10; k++) begin
            apply(1'b0, 1'b0, 1'b1, 16'd7);
            vectors++;
            if (pc.out !== 16'(k)) begin
                miscompares++;
                $display("FAIL inc_after_load: out=%h expected=%h", pc.out, 16'(k));
            end
        end
        apply(1'b1, 1'b1, 1'b1, 16'h1234);
        vectors++;
        if (pc.out !== 16'(RV)) begin
            miscompares++;
            $display("FAIL clear_over_load: out=%h expected=%h", pc.out, 16'(RV));
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] vals [4];
        apply(1'b0, 1'b1, 1'b0, 16'h0A5A);
        vals[0] = 16'd7;
        vals[1] = 16'd100;
        vals[2] = 16'hFFFF;
        vals[3] = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, 1'b0, vals[k]);
            vectors++;
            if (pc.out !== 16'h0A5A) begin
                miscompares++;
                $display("FAIL hold_%0d: out=%h expected=0a5a", k, pc.out);
            end
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b1, 1'b0, 16'hFFFF);
        vectors++;
        if (pc.out !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_load: out=%h expected=ffff", pc.out);
        end
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        vectors++;
        if (pc.out !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_zero: out=%h expected=0000", pc.out);
        end
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        vectors++;
        if (pc.out !== 16'h0001) begin
            miscompares++;
            $display("FAIL wrap_one: out=%h expected=0001", pc.out);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b0, 1'b1, 1'b0, 16'h0122);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        vectors++;
        if (pc.out !== 16'h0123) begin
            miscompares++;
            $display("FAIL pre_reset_count: out=%h expected=0123", pc.out);
        end
        // Controls for a pending load are already applied when reset hits
        pc.load = 1'b1;
        pc.in   = 16'hBEEF;
        #1 reset = 1'b0;
        #1;
        exp_pc = RV;
        vectors++;
        if (pc.out !== 16'(exp_pc)) begin
            miscompares++;
            $display("FAIL async_mid_count: out=%h expected=%h", pc.out, 16'(exp_pc));
        end
        @(negedge clock);
        reset = 1'b1;
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        vectors++;
        if (pc.out !== 16'h0001) begin
            miscompares++;
            $display("FAIL post_reset_inc: out=%h expected=0001", pc.out);
        end
    endtask

    task automatic test_random();
        logic          c, l, i;
        logic [W-1:0]  d;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            apply(c, l, i, d);
            vectors++;
            if (pc.out !== 16'(exp_pc)) begin
                miscompares++;
                $display("FAIL random_%0d: out=%h expected=%h", n, pc.out, 16'(exp_pc));
            end
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                #1;
                exp_pc = RV;
                vectors++;
                if (pc.out !== 16'(exp_pc)) begin
                    miscompares++;
                    $display("FAIL random_reset_%0d: out=%h expected=%h", n, pc.out, 16'(exp_pc));
                end
                @(negedge clock);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_pc      = RV;
        test_reset();
        test_clear_count();
        test_load_priority();
        test_hold();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_program_counter
